// File: rtl/sprite_slot_compositor.sv
// sprite_slot_compositor
// Walks the four per-pixel sprite hit slots from highest (h3) to lowest (h0)
// priority, fetches each non-empty slot's pixel from sprite memory over a
// req/ack port and reports the first opaque colour, or the latched background
// colour when every slot is empty or transparent.
//
// Optional build macro: SPRITE_COMPOSITOR_TIMEOUT_EN
//   Adds a fetch watchdog. A fetch that sees no mem_ack for TIMEOUT_CYCLES
//   cycles is abandoned and handled like a transparent pixel, and the sticky
//   err_timeout flag is raised until reset. Without the macro FETCH waits
//   indefinitely and err_timeout is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a slot set; in_ready high
// SCAN  | inspect slot[idx]; skip if empty, otherwise launch a fetch
// FETCH | mem_req/mem_addr held until mem_ack (or watchdog expiry)
// DONE  | out_valid strobe for one cycle; result registers already loaded

module sprite_slot_compositor #(
  parameter int                 ADDR_W            = 18,
  parameter int                 COLOR_W           = 9,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 9'h1C7,
  parameter int                 TIMEOUT_CYCLES    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W+4:0]  h3_in,
  input  logic [ADDR_W+4:0]  h2_in,
  input  logic [ADDR_W+4:0]  h1_in,
  input  logic [ADDR_W+4:0]  h0_in,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [COLOR_W-1:0] mem_data,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_hit,
  output logic [4:0]         out_tag,
  output logic               err_timeout
);

  localparam int SLOT_W = ADDR_W + 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [3:0][SLOT_W-1:0]   slot_q, slot_d;
  logic [COLOR_W-1:0]       bg_q, bg_d;
  logic                     req_q, req_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [COLOR_W-1:0]       color_q, color_d;
  logic                     hit_q, hit_d;
  logic [4:0]               tag_q, tag_d;

  logic [SLOT_W-1:0]        cur_slot;
  logic                     tmo_fire;

  assign cur_slot = slot_q[idx_q];

  // Next-state and datapath decode for the slot walk
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    bg_d    = bg_q;
    req_d   = req_q;
    addr_d  = addr_q;
    color_d = color_q;
    hit_d   = hit_q;
    tag_d   = tag_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          slot_d[3] = h3_in;
          slot_d[2] = h2_in;
          slot_d[1] = h1_in;
          slot_d[0] = h0_in;
          bg_d      = bg_color;
          idx_d     = 2'd3;
          state_d   = S_SCAN;
        end
      end

      S_SCAN: begin
        if (cur_slot == '0) begin
          if (idx_q == 2'd0) begin
            color_d = bg_q;
            hit_d   = 1'b0;
            tag_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end else begin
          // A zero address with a non-zero tag is a real hit at address 0
          addr_d  = cur_slot[ADDR_W-1:0];
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (mem_ack && (mem_data != TRANSPARENT_COLOR)) begin
          color_d = mem_data;
          hit_d   = 1'b1;
          tag_d   = cur_slot[SLOT_W-1 -: 5];
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (mem_ack || tmo_fire) begin
          // Transparent pixel or abandoned fetch: fall through to the next slot
          req_d = 1'b0;
          if (idx_q == 2'd0) begin
            color_d = bg_q;
            hit_d   = 1'b0;
            tag_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 2'd1;
            state_d = S_SCAN;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, slot latches, memory port and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      slot_q  <= '0;
      bg_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      color_q <= '0;
      hit_q   <= 1'b0;
      tag_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      bg_q    <= bg_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      color_q <= color_d;
      hit_q   <= hit_d;
      tag_q   <= tag_d;
    end
  end

`ifdef SPRITE_COMPOSITOR_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Terminal count reached in FETCH with still no acknowledge
  assign tmo_fire = (state_q == S_FETCH) && !mem_ack && (tmo_q == '0);

  // Watchdog down-counter reloads on every entry to FETCH
  always_comb begin
    tmo_d = tmo_q;
    if ((state_q == S_SCAN) && (state_d == S_FETCH)) begin
      tmo_d = TMO_LOAD;
    end else if ((state_q == S_FETCH) && (tmo_q != '0)) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
    err_d = err_q | tmo_fire;
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_tmo_cfg;

  assign tmo_fire       = 1'b0;
  assign err_timeout    = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign out_color = color_q;
  assign out_hit   = hit_q;
  assign out_tag   = tag_q;

endmodule

// File: doc/sprite_slot_compositor.md
Name: sprite_slot_compositor

Overview:
- Consumes the four per-pixel sprite hit slots from the top-4 selector (h3 = highest priority … h0 = lowest).
- Fetches each hit's pixel from sprite memory over a req/ack port, in priority order.
- Emits the first non-transparent colour, or the background colour if no slot is opaque.
- Sits between the selector and the VGA colour mux in the visual processing unit.

Parameters:
- ADDR_W, 18, sprite memory address width (equals the slot payload width).
- COLOR_W, 9, pixel colour width (RGB 3:3:3).
- TRANSPARENT_COLOR, 9'h1C7, colour value treated as transparent.
- TIMEOUT_CYCLES, 16, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  slot set valid for the current pixel.
- in_ready  out  1  high only in IDLE; a slot set is accepted on any edge with in_valid & in_ready.
- h3_in,h2_in,h1_in,h0_in  in  23 each  slot word: [22:18] priority tag, [17:0] pixel address; all-zero word = empty slot.
- bg_color  in  COLOR_W  background colour, sampled at accept.
- mem_req  out  1  fetch request (registered).
- mem_addr  out  ADDR_W  fetch address (registered).
- mem_ack  in  1  fetch complete; mem_data is valid in the same cycle.
- mem_data  in  COLOR_W  fetched pixel colour.
- out_valid  out  1  one-cycle result strobe.
- out_color  out  COLOR_W  composited colour.
- out_hit  out  1  1 = a sprite pixel won; 0 = background.
- out_tag  out  5  tag of the winning slot; 0 if background.
- err_timeout  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset: state=IDLE. All outputs 0 except in_ready=1. Slot registers cleared.
- IDLE: on accept, latch h3..h0 and bg_color; set idx=3; go to SCAN.
- SCAN (one slot per cycle):
  - slot[idx]==0: if idx==0 go to DONE with background, else idx-1.
  - otherwise: mem_addr=slot[idx][17:0], mem_req=1, go to FETCH.
- FETCH: hold mem_req and mem_addr until a cycle with mem_ack=1. On that edge:
  - mem_data != TRANSPARENT_COLOR: capture colour, out_hit=1, out_tag=slot[idx][22:18]; deassert mem_req; go to DONE.
  - mem_data == TRANSPARENT_COLOR: deassert mem_req; go to SCAN with idx-1, or to DONE with background if idx==0.
- DONE: out_valid=1 for exactly one cycle, then IDLE.
- Background result: out_color=latched bg_color, out_hit=0, out_tag=0.
- out_color, out_hit and out_tag are registered and hold their value until the next DONE.
- Latency from the accept edge to out_valid:
  - all slots empty: 4 cycles.
  - h3 opaque with ack in its first FETCH cycle: 2 cycles.
  - general case: one cycle per SCAN step plus each FETCH duration, plus 1 for DONE.
- Boundary conditions:
  - in_valid while not IDLE (including DONE) is ignored; in_ready=0 there, and the inputs are not re-sampled.
  - Slot contents changing after accept have no effect.
  - mem_ack outside FETCH is ignored.
  - A slot with non-zero tag and zero address is still non-empty and is fetched at address 0.
  - Reset mid-fetch drops mem_req on the next edge, returns to IDLE and clears err_timeout.
  - mem_req never asserts for empty slots and never for more than one slot at a time.

Optional Feature:
- Macro: SPRITE_COMPOSITOR_TIMEOUT_EN.
- Defined:
  - A counter runs in FETCH and clears on entry to FETCH.
  - If TIMEOUT_CYCLES cycles pass without mem_ack, the fetch is abandoned and treated as transparent (same transitions as a transparent ack).
  - err_timeout is set and stays set until reset.
- Undefined: no counter; FETCH waits indefinitely; err_timeout tied to 0.

Test Plan:
- All four slots zero, bg_color=9'h0AA -> out_valid 4 cycles after accept; out_color=9'h0AA, out_hit=0, out_tag=0; mem_req never asserts.
- h3={5'd1,18'h00100}, mem_ack same cycle with mem_data=9'h038 -> mem_addr=18'h00100; out_valid 2 cycles after accept; out_color=9'h038, out_hit=1, out_tag=1; exactly one request.
- h3 returns 9'h1C7 (transparent), h2 empty, h1={5'd3,18'h00200} returns 9'h007 -> two requests, in order 0x..., 00200 after h3's address; out_color=9'h007, out_tag=3.
- mem_ack delayed 5 cycles; in_valid pulsed while busy -> mem_req and mem_addr stable throughout; in_ready=0; second set ignored; one out_valid only.
- Reset asserted while in FETCH -> next cycle: mem_req=0, in_ready=1, out_valid=0; a new accept then completes normally.
- With SPRITE_COMPOSITOR_TIMEOUT_EN and no mem_ack on h3 (only slot) -> abort after 16 cycles; background output; err_timeout=1 and sticky until reset.
